// File: rtl/conv1_if.sv
// Tap/result handshake bundle for the conv-1 accumulator.
//   bias      signed bias, used only with the first tap of a window
//   pix       unsigned pixel
//   wgt       signed weight
//   in_valid  upstream offers pix/wgt/bias
//   in_ready  accumulator accepts a tap
//   sum       clamped unsigned window sum
//   out_valid sum is valid
//   out_ready downstream accepts sum
interface conv1_if #(
  parameter int unsigned OUT_W = 20
);
  logic [19:0]      bias;
  logic [7:0]       pix;
  logic [7:0]       wgt;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;

  // Producer/consumer side (drives taps, consumes sums)
  modport master (
    output bias, pix, wgt, in_valid, out_ready,
    input  in_ready, sum, out_valid
  );

  // Accumulator side
  modport slave (
    input  bias, pix, wgt, in_valid, out_ready,
    output in_ready, sum, out_valid
  );
endinterface

// File: rtl/conv1_accumulator.sv
// Conv-1 multiply-accumulate: sums TAPS pixel*weight products plus a bias
// per window, clamps the result to [0, 2^OUT_W-1] and holds it until the
// downstream stage takes it.
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  conv1_if slave: tap input handshake and sum output handshake
// OUT_W must be at most 25 so the clamp limit fits the accumulator.
module conv1_accumulator #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned OUT_W = 20
) (
  input  logic    clk,
  input  logic    rst,
  conv1_if.slave  bus
);

  localparam int unsigned ACC_W  = 26;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          sum_q, sum_d;
  logic                      out_valid_q, out_valid_d;

  logic                      accept;
  logic                      last_tap;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_next;
  logic [OUT_W-1:0]          sum_clamp;

  // Ready depends only on state and reset so a sum handshake can never
  // overlap acceptance of the next window's first tap.
  assign bus.in_ready  = (state_q != HOLD) && !rst;
  assign bus.sum       = sum_q;
  assign bus.out_valid = out_valid_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_tap = (cnt_q == CNT_W'(TAPS - 1));

  // Zero-extended pixel times sign-extended weight
  assign prod     = PROD_W'($signed({1'b0, bus.pix})) * PROD_W'($signed(bus.wgt));
  // First tap of a window seeds the sum with the bias instead of acc_q
  assign acc_base = (state_q == IDLE) ? ACC_W'($signed(bus.bias)) : acc_q;
  assign acc_next = acc_base + ACC_W'(prod);

  // Saturate the running sum into the unsigned output range
  always_comb begin
    sum_clamp = acc_next[OUT_W-1:0];
    if (acc_next[ACC_W-1]) begin
      sum_clamp = '0;
    end else if (acc_next > SUM_MAX) begin
      sum_clamp = '1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          if (last_tap) begin
            state_d = HOLD;
            cnt_d   = '0;
            sum_d   = sum_clamp;
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    out_valid_d = (state_d == HOLD);
  end

endmodule
